// File: rtl/alu_writeback_ctrl_pkg.sv
//------------------------------------------------------------------------------
// Module  : alu_writeback_ctrl_pkg
// Brief   : Opcode, FSM state and instruction-layout constants for the
//           execute/writeback controller.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package alu_writeback_ctrl_pkg;

    localparam logic [2:0] c_op_add  = 3'b000;
    localparam logic [2:0] c_op_sub  = 3'b001;
    localparam logic [2:0] c_op_and  = 3'b010;
    localparam logic [2:0] c_op_or   = 3'b011;
    localparam logic [2:0] c_op_xor  = 3'b100;
    localparam logic [2:0] c_op_sltu = 3'b101;
    localparam logic [2:0] c_op_mul  = 3'b110;
    localparam logic [2:0] c_op_nop  = 3'b111;

    localparam logic [2:0] c_st_idle = 3'd0;
    localparam logic [2:0] c_st_read = 3'd1;
    localparam logic [2:0] c_st_exec = 3'd2;
    localparam logic [2:0] c_st_mul  = 3'd3;
    localparam logic [2:0] c_st_wb   = 3'd4;

    // Instruction layout {op, rd, ra, rb}: LSB offset of each field.
    function automatic int rb_lsb(input int bit_addr);
        return 0;
    endfunction

    function automatic int ra_lsb(input int bit_addr);
        return bit_addr;
    endfunction

    function automatic int rd_lsb(input int bit_addr);
        return 2 * bit_addr;
    endfunction

    function automatic int op_lsb(input int bit_addr);
        return 3 * bit_addr;
    endfunction

endpackage

`default_nettype wire

// File: rtl/alu_writeback_ctrl_alu_comb.sv
//------------------------------------------------------------------------------
// Module  : alu_comb
// Brief   : Combinational ALU for every opcode except MUL.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module alu_comb
    import alu_writeback_ctrl_pkg::*;
#(
    parameter int BIT_DATO = 8
) (
    input  logic [2:0]          i_op,
    input  logic [BIT_DATO-1:0] i_a,
    input  logic [BIT_DATO-1:0] i_b,
    output logic [BIT_DATO-1:0] o_result,
    output logic                o_carry,
    output logic                o_zero
);

    logic [BIT_DATO:0] w_sum;

    always_comb begin
        w_sum    = '0;
        o_result = '0;
        o_carry  = 1'b0;
        case (i_op)
            c_op_add: begin
                w_sum    = {1'b0, i_a} + {1'b0, i_b};
                o_result = w_sum[BIT_DATO-1:0];
                o_carry  = w_sum[BIT_DATO];
            end
            // The extra top bit of the difference is the borrow (A < B).
            c_op_sub: begin
                w_sum    = {1'b0, i_a} - {1'b0, i_b};
                o_result = w_sum[BIT_DATO-1:0];
                o_carry  = w_sum[BIT_DATO];
            end
            c_op_and:  o_result = i_a & i_b;
            c_op_or:   o_result = i_a | i_b;
            c_op_xor:  o_result = i_a ^ i_b;
            c_op_sltu: o_result = {{(BIT_DATO-1){1'b0}}, (i_a < i_b)};
            default:   o_result = '0;
        endcase
        o_zero = (o_result == '0);
    end

endmodule

`default_nettype wire

// File: rtl/alu_writeback_ctrl.sv
//------------------------------------------------------------------------------
// Module  : alu_writeback_ctrl
// Brief   : Single-issue execute stage around a 2R/1W register bank with an
//           iterative shift-add multiplier and registered writeback.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module alu_writeback_ctrl
    import alu_writeback_ctrl_pkg::*;
#(
    parameter int BIT_ADDR = 4,
    parameter int BIT_DATO = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    instr_valid,
    output logic                    instr_ready,
    input  logic [3+3*BIT_ADDR-1:0] instr,
    output logic [BIT_ADDR-1:0]     addrRa,
    output logic [BIT_ADDR-1:0]     addrRb,
    input  logic [BIT_DATO-1:0]     datOutRa,
    input  logic [BIT_DATO-1:0]     datOutRb,
    output logic                    RegWrite,
    output logic [BIT_ADDR-1:0]     addrW,
    output logic [BIT_DATO-1:0]     datW,
    output logic                    busy,
    output logic                    done,
    output logic                    flag_zero,
    output logic                    flag_carry
);

    localparam int CW = $clog2(BIT_DATO + 1);
    localparam logic [CW-1:0] c_mul_steps = CW'(BIT_DATO);
    localparam logic [CW-1:0] c_cnt_one   = CW'(1);

    logic [2:0]          state_q,  state_d;
    logic [2:0]          op_q,     op_d;
    logic [BIT_ADDR-1:0] rd_q,     rd_d;
    logic [BIT_ADDR-1:0] ra_q,     ra_d;
    logic [BIT_ADDR-1:0] rb_q,     rb_d;
    logic [BIT_DATO-1:0] opa_q,    opa_d;
    logic [BIT_DATO-1:0] opb_q,    opb_d;
    logic [BIT_DATO-1:0] acc_q,    acc_d;
    logic [CW-1:0]       cnt_q,    cnt_d;
    logic [BIT_DATO-1:0] result_q, result_d;
    logic                zero_q,   zero_d;
    logic                carry_q,  carry_d;

    logic [BIT_DATO-1:0] w_alu_result;
    logic                w_alu_carry;
    logic                w_alu_zero;
    logic [BIT_DATO-1:0] w_acc_next;

    alu_comb #(
        .BIT_DATO (BIT_DATO)
    ) u_alu (
        .i_op     (op_q),
        .i_a      (opa_q),
        .i_b      (opb_q),
        .o_result (w_alu_result),
        .o_carry  (w_alu_carry),
        .o_zero   (w_alu_zero)
    );

    assign w_acc_next = opb_q[0] ? (acc_q + opa_q) : acc_q;

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        rd_d     = rd_q;
        ra_d     = ra_q;
        rb_d     = rb_q;
        opa_d    = opa_q;
        opb_d    = opb_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        zero_d   = zero_q;
        carry_d  = carry_q;
        case (state_q)
            c_st_idle: begin
                if (instr_valid) begin
                    op_d    = instr[op_lsb(BIT_ADDR) +: 3];
                    rd_d    = instr[rd_lsb(BIT_ADDR) +: BIT_ADDR];
                    ra_d    = instr[ra_lsb(BIT_ADDR) +: BIT_ADDR];
                    rb_d    = instr[rb_lsb(BIT_ADDR) +: BIT_ADDR];
                    state_d = c_st_read;
                end
            end
            c_st_read: begin
                opa_d   = datOutRa;
                opb_d   = datOutRb;
                state_d = c_st_exec;
            end
            c_st_exec: begin
                if (op_q == c_op_nop) begin
                    state_d = c_st_idle;
                end else if (op_q == c_op_mul) begin
                    acc_d   = '0;
                    cnt_d   = c_mul_steps;
                    state_d = c_st_mul;
                end else begin
                    result_d = w_alu_result;
                    zero_d   = w_alu_zero;
                    carry_d  = w_alu_carry;
                    state_d  = c_st_wb;
                end
            end
            c_st_mul: begin
                acc_d = w_acc_next;
                opa_d = opa_q << 1;
                opb_d = opb_q >> 1;
                cnt_d = cnt_q - c_cnt_one;
                // Last step: the updated accumulator is the final product.
                if (cnt_q == c_cnt_one) begin
                    result_d = w_acc_next;
                    zero_d   = (w_acc_next == '0);
                    carry_d  = 1'b0;
                    state_d  = c_st_wb;
                end
            end
            c_st_wb:  state_d = c_st_idle;
            default:  state_d = c_st_idle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= c_st_idle;
            op_q     <= '0;
            rd_q     <= '0;
            ra_q     <= '0;
            rb_q     <= '0;
            opa_q    <= '0;
            opb_q    <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            zero_q   <= 1'b0;
            carry_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            rd_q     <= rd_d;
            ra_q     <= ra_d;
            rb_q     <= rb_d;
            opa_q    <= opa_d;
            opb_q    <= opb_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            carry_q  <= carry_d;
        end
    end

    assign instr_ready = rst && (state_q == c_st_idle);
    assign busy        = (state_q != c_st_idle);
    assign done        = (state_q == c_st_wb) || ((state_q == c_st_exec) && (op_q == c_op_nop));
    assign RegWrite    = (state_q == c_st_wb);
    assign addrRa      = ra_q;
    assign addrRb      = rb_q;
    assign addrW       = rd_q;
    assign datW        = result_q;
    assign flag_zero   = zero_q;
    assign flag_carry  = carry_q;

endmodule

`default_nettype wire
